bullet_pool: RTL

Player-bullet manager holding up to NUM_BULLETS independent shots, replacing the single-shot bullet block.
- Edge-detects the fire key and allocates a free slot.
- Latches the player X at fire time and moves each live shot upward once per frame.
- Retires a shot on ceiling or hit.
- Sits between the keyboard keycode path and the collision/colour-mapper logic; runs entirely in the frame_clk domain.

---
 rtl/bullet_pool_pkg.sv | 17 +
 rtl/bullet_pool_if.sv | 28 ++
 rtl/bullet_pool_slot.sv | 72 +++++++
 rtl/bullet_pool.sv | 106 ++++++++++
 4 files changed

// File: rtl/bullet_pool_pkg.sv
// rtl/bullet_pool_pkg.sv - shared types and defaults for the player bullet pool
// Defaults for Y_START/Y_MIN are shared with the player and alien blocks.
package bullet_pool_pkg;

  localparam int         COORD_W_DEF = 10;
  localparam int         Y_START_DEF = 420;
  localparam int         Y_MIN_DEF   = 8;
  localparam logic [7:0] KEY_SPACE   = 8'h2C;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_e;

endpackage

// File: rtl/bullet_pool_if.sv
// rtl/bullet_pool_if.sv - keyboard/collision side signals of the bullet pool
// master drives keycode/player X/hit; slave is the pool itself.
interface bullet_pool_if #(
  parameter int NUM_BULLETS = 4,
  parameter int COORD_W     = 10
);
  localparam int CNT_W = $clog2(NUM_BULLETS + 1);

  logic [7:0]                     keycode;
  logic [COORD_W-1:0]             player_X_position;
  logic [NUM_BULLETS-1:0]         hit;
  logic [NUM_BULLETS*COORD_W-1:0] bullet_X;
  logic [NUM_BULLETS*COORD_W-1:0] bullet_Y;
  logic [NUM_BULLETS-1:0]         bullet_on_screen;
  logic                           fire_accepted;
  logic [CNT_W-1:0]               free_count;

  modport master (
    output keycode, player_X_position, hit,
    input  bullet_X, bullet_Y, bullet_on_screen, fire_accepted, free_count
  );

  modport slave (
    input  keycode, player_X_position, hit,
    output bullet_X, bullet_Y, bullet_on_screen, fire_accepted, free_count
  );

endinterface

// File: rtl/bullet_pool_slot.sv
// rtl/bullet_pool_slot.sv - one bullet slot: IDLE/FLYING FSM with latched X and moving Y
// live_next exposes the post-edge state so the top can register an exact free count.
module bullet_pool_slot
  import bullet_pool_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int Y_START = 420,
  parameter int Y_MIN   = 8,
  parameter int Y_STEP  = 4
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic               alloc,
  input  logic [COORD_W-1:0] player_x,
  input  logic               hit,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               live,
  output logic               live_next
);

  // Widened by one bit so Y_MIN+Y_STEP never wraps and Y is never decremented below zero.
  localparam logic [COORD_W:0]   CEIL    = (COORD_W + 1)'(Y_MIN + Y_STEP);
  localparam logic [COORD_W-1:0] Y_LOAD  = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0] Y_DELTA = COORD_W'(Y_STEP);

  slot_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= SLOT_IDLE;
      x_q     <= '0;
      y_q     <= Y_LOAD;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      SLOT_IDLE: begin
        if (alloc) begin
          state_d = SLOT_FLYING;
          x_d     = player_x;
          y_d     = Y_LOAD;
        end
      end
      SLOT_FLYING: begin
        if (hit || ({1'b0, y_q} < CEIL)) begin
          state_d = SLOT_IDLE;
          y_d     = Y_LOAD;
        end else begin
          y_d = y_q - Y_DELTA;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  assign x         = x_q;
  assign y         = y_q;
  assign live      = (state_q == SLOT_FLYING);
  assign live_next = (state_d == SLOT_FLYING);

endmodule

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - multi-shot player bullet manager in the frame_clk domain
// Edge-detects the fire key, applies cooldown, allocates the lowest idle slot.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int         NUM_BULLETS = 4,
  parameter int         COORD_W     = COORD_W_DEF,
  parameter int         Y_START     = Y_START_DEF,
  parameter int         Y_MIN       = Y_MIN_DEF,
  parameter int         Y_STEP      = 4,
  parameter int         COOLDOWN    = 8,
  parameter logic [7:0] FIRE_KEY    = KEY_SPACE
) (
  input  logic          frame_clk,
  input  logic          Reset_n,
  bullet_pool_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_BULLETS + 1);
  localparam int CD_W  = $clog2(COOLDOWN + 2);

  if (NUM_BULLETS < 1 || NUM_BULLETS > 8) begin : g_bad_num
    $error("bullet_pool: NUM_BULLETS must be within 1..8");
  end
  if (Y_START < Y_MIN) begin : g_bad_y
    $error("bullet_pool: Y_START must not be below Y_MIN");
  end

  logic                   key_prev_q, key_prev_d;
  logic [CD_W-1:0]        cooldown_q, cooldown_d;
  logic                   fire_acc_q, fire_acc_d;
  logic [CNT_W-1:0]       free_count_q, free_count_d;

  logic                   key_now;
  logic                   accept;
  logic [NUM_BULLETS-1:0] live;
  logic [NUM_BULLETS-1:0] live_next;
  logic [NUM_BULLETS-1:0] alloc;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_prev_q   <= 1'b0;
      cooldown_q   <= '0;
      fire_acc_q   <= 1'b0;
      free_count_q <= CNT_W'(NUM_BULLETS);
    end else begin
      key_prev_q   <= key_prev_d;
      cooldown_q   <= cooldown_d;
      fire_acc_q   <= fire_acc_d;
      free_count_q <= free_count_d;
    end
  end

  assign key_now = (bus.keycode == FIRE_KEY);

  // Allocation looks only at registered state, so a slot retiring this frame is not reused yet.
  always_comb begin
    logic found;
    key_prev_d = key_now;
    accept     = key_now && !key_prev_q && (cooldown_q == '0) && !(&live);
    alloc      = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!live[i] && !found) begin
        alloc[i] = accept;
        found    = 1'b1;
      end
    end
    fire_acc_d = accept;
    if (accept) begin
      cooldown_d = CD_W'(COOLDOWN);
    end else if (cooldown_q != '0) begin
      cooldown_d = cooldown_q - CD_W'(1);
    end else begin
      cooldown_d = '0;
    end
    free_count_d = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      free_count_d = free_count_d + CNT_W'(live_next[i] ? 1'b0 : 1'b1);
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_pool_slot #(
      .COORD_W (COORD_W),
      .Y_START (Y_START),
      .Y_MIN   (Y_MIN),
      .Y_STEP  (Y_STEP)
    ) u_slot (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .alloc     (alloc[i]),
      .player_x  (bus.player_X_position),
      .hit       (bus.hit[i]),
      .x         (bus.bullet_X[i*COORD_W +: COORD_W]),
      .y         (bus.bullet_Y[i*COORD_W +: COORD_W]),
      .live      (live[i]),
      .live_next (live_next[i])
    );
  end

  assign bus.bullet_on_screen = live;
  assign bus.fire_accepted    = fire_acc_q;
  assign bus.free_count       = free_count_q;

endmodule
